// File: rtl/hevc_filter_feeder_pkg.sv
// Shared types and constants for the HEVC interpolation job feeder.
package hevc_feeder_pkg;

   localparam int unsigned CNT_W    = 13;
   localparam int unsigned TAP4_EXT = 3;
   localparam int unsigned TAP8_EXT = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CFG   = 2'd1,
      FEED  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // Block sizes the interpolation dataflow supports.
   function automatic logic size_legal(input int unsigned size);
      return (size == 4) || (size == 8) || (size == 16) || (size == 32) || (size == 64);
   endfunction

endpackage

// File: rtl/hevc_filter_feeder_counter.sv
// Terminal-count counter: cleared at job start, last_c flags the increment that reaches term.
module hevc_feed_counter
   import hevc_feeder_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] count,
   output logic             last_c
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign last_c = inc && (count_q == term - CNT_W'(1));

endmodule

// File: rtl/hevc_filter_feeder.sv
// Job sequencer feeding config tokens and reference pixels into the HEVC interpolation dataflow.
// Optional FEEDER_CHECKSUM_EN adds a chk port with a mod-2^16 sum of the job's counted outputs.
module hevc_filter_feeder
   import hevc_feeder_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned SIZE_W  = 7,
   parameter int unsigned ALPHA_W = 3,
   parameter int unsigned FLUX    = 2,
   parameter int unsigned TAG_W   = (FLUX > 1) ? $clog2(FLUX) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [SIZE_W-1:0]  cmd_size,
   input  logic               cmd_tap8,
   input  logic [ALPHA_W-1:0] cmd_v_alpha,
   input  logic [ALPHA_W-1:0] cmd_h_alpha,
   input  logic [TAG_W-1:0]   cmd_tag,
   input  logic               src_valid,
   output logic               src_ready,
   input  logic [DATA_W-1:0]  src_data,
   output logic               cfg_write,
   output logic [ALPHA_W:0]   cfg_v_din,
   output logic [ALPHA_W:0]   cfg_h_din,
   output logic [SIZE_W:0]    cfg_size_din,
   input  logic [FLUX-1:0]    cfg_full,
   output logic               pel_write,
   output logic [DATA_W:0]    pel_din,
   output logic [TAG_W-1:0]   pel_tag,
   output logic [TAG_W-1:0]   cfg_tag,
   input  logic [FLUX-1:0]    pel_full,
   input  logic               res_write,
   input  logic [DATA_W:0]    res_din,
   input  logic [TAG_W-1:0]   res_tag,
   output logic               res_full,
   output logic               snk_valid,
   input  logic               snk_ready,
   output logic [DATA_W-1:0]  snk_data,
   output logic               done,
   output logic               err,
`ifdef FEEDER_CHECKSUM_EN
   output logic [15:0]        chk,
`endif
   output logic               busy
);

   state_e             state_q, state_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [ALPHA_W-1:0] v_alpha_q, v_alpha_d;
   logic [ALPHA_W-1:0] h_alpha_q, h_alpha_d;
   logic [SIZE_W-1:0]  ext_q, ext_d;
   logic [CNT_W-1:0]   n_in_q, n_in_d;
   logic [CNT_W-1:0]   n_out_q, n_out_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               cfg_write_q, cfg_write_d;
   logic [ALPHA_W:0]   cfg_v_din_q, cfg_v_din_d;
   logic [ALPHA_W:0]   cfg_h_din_q, cfg_h_din_d;
   logic [SIZE_W:0]    cfg_size_din_q, cfg_size_din_d;
   logic               pel_write_q, pel_write_d;
   logic [DATA_W:0]    pel_din_q, pel_din_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic               cnt_clr;
   logic               cmd_fire;
   logic               xfer;
   logic               out_phase;
   logic               counted;
   logic               bad_out;
   logic               out_reached;
   logic               out_done;
   logic               in_last, out_last;
   logic [CNT_W-1:0]   in_cnt, out_cnt;
   logic [SIZE_W-1:0]  ext_c;

   assign ext_c    = cmd_size + (cmd_tap8 ? SIZE_W'(TAP8_EXT) : SIZE_W'(TAP4_EXT));
   assign cmd_fire = (state_q == IDLE) && cmd_valid && cmd_ready_q;

   assign src_ready = (state_q == FEED) && !pel_full[tag_q] && (in_cnt != n_in_q);
   assign xfer      = src_valid && src_ready;

   // Result stream is forwarded unconditionally; only well-formed results of this job count.
   assign out_phase   = (state_q == FEED) || (state_q == DRAIN);
   assign out_reached = (out_cnt == n_out_q);
   assign counted     = res_write && out_phase && (res_tag == tag_q) && res_din[DATA_W] && !out_reached;
   assign bad_out     = res_write && !(out_phase && (res_tag == tag_q) && res_din[DATA_W]);
   assign out_done    = out_last || out_reached;

   assign snk_valid = res_write;
   assign snk_data  = res_din[DATA_W-1:0];
   assign res_full  = !snk_ready;

   hevc_feed_counter u_in_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (xfer),
      .term   (n_in_q),
      .count  (in_cnt),
      .last_c (in_last)
   );

   hevc_feed_counter u_out_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (counted),
      .term   (n_out_q),
      .count  (out_cnt),
      .last_c (out_last)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      tag_d          = tag_q;
      v_alpha_d      = v_alpha_q;
      h_alpha_d      = h_alpha_q;
      ext_d          = ext_q;
      n_in_d         = n_in_q;
      n_out_d        = n_out_q;
      cfg_write_d    = 1'b0;
      cfg_v_din_d    = '0;
      cfg_h_din_d    = '0;
      cfg_size_din_d = '0;
      pel_write_d    = xfer;
      pel_din_d      = xfer ? {1'b1, src_data} : '0;
      done_d         = 1'b0;
      err_d          = bad_out;
      cnt_clr        = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               tag_d     = cmd_tag;
               v_alpha_d = cmd_v_alpha;
               h_alpha_d = cmd_h_alpha;
               ext_d     = ext_c;
               n_in_d    = CNT_W'(ext_c) * CNT_W'(ext_c);
               n_out_d   = CNT_W'(cmd_size) * CNT_W'(cmd_size);
               if (size_legal(32'(cmd_size))) begin
                  state_d = CFG;
                  cnt_clr = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CFG: begin
            if (!cfg_full[tag_q]) begin
               cfg_write_d    = 1'b1;
               cfg_v_din_d    = {1'b1, v_alpha_q};
               cfg_h_din_d    = {1'b1, h_alpha_q};
               cfg_size_din_d = {1'b1, ext_q};
               state_d        = FEED;
            end
         end
         FEED: begin
            if (in_last) begin
               if (out_done) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (out_done) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      cmd_ready_d = (state_d == IDLE) && !cmd_fire;
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         tag_q          <= '0;
         v_alpha_q      <= '0;
         h_alpha_q      <= '0;
         ext_q          <= '0;
         n_in_q         <= '0;
         n_out_q        <= '0;
         cmd_ready_q    <= 1'b1;
         cfg_write_q    <= 1'b0;
         cfg_v_din_q    <= '0;
         cfg_h_din_q    <= '0;
         cfg_size_din_q <= '0;
         pel_write_q    <= 1'b0;
         pel_din_q      <= '0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         tag_q          <= tag_d;
         v_alpha_q      <= v_alpha_d;
         h_alpha_q      <= h_alpha_d;
         ext_q          <= ext_d;
         n_in_q         <= n_in_d;
         n_out_q        <= n_out_d;
         cmd_ready_q    <= cmd_ready_d;
         cfg_write_q    <= cfg_write_d;
         cfg_v_din_q    <= cfg_v_din_d;
         cfg_h_din_q    <= cfg_h_din_d;
         cfg_size_din_q <= cfg_size_din_d;
         pel_write_q    <= pel_write_d;
         pel_din_q      <= pel_din_d;
         done_q         <= done_d;
         err_q          <= err_d;
         busy_q         <= busy_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign cfg_write    = cfg_write_q;
   assign cfg_v_din    = cfg_v_din_q;
   assign cfg_h_din    = cfg_h_din_q;
   assign cfg_size_din = cfg_size_din_q;
   assign cfg_tag      = tag_q;
   assign pel_write    = pel_write_q;
   assign pel_din      = pel_din_q;
   assign pel_tag      = tag_q;
   assign done         = done_q;
   assign err          = err_q;
   assign busy         = busy_q;

`ifdef FEEDER_CHECKSUM_EN
   logic [15:0] chk_q, chk_d;

   // Restarts with each accepted job and holds after done until the next one.
   always_comb begin
      chk_d = chk_q;
      if (cnt_clr) begin
         chk_d = '0;
      end else if (counted) begin
         chk_d = chk_q + 16'(res_din[DATA_W-1:0]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end

   assign chk = chk_q;
`endif

endmodule

// File: tb/tb_hevc_filter_feeder.sv
// Scoreboard bench for hevc_filter_feeder: predicted pixels queued at the source, popped at pel_write.
module tb_hevc_filter_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready;
   logic [6:0] cmd_size;
   logic       cmd_tap8;
   logic [2:0] cmd_v_alpha, cmd_h_alpha;
   logic [0:0] cmd_tag;
   logic       src_valid, src_ready;
   logic [7:0] src_data;
   logic       cfg_write;
   logic [3:0] cfg_v_din, cfg_h_din;
   logic [7:0] cfg_size_din;
   logic [1:0] cfg_full;
   logic       pel_write;
   logic [8:0] pel_din;
   logic [0:0] pel_tag, cfg_tag;
   logic [1:0] pel_full;
   logic       res_write;
   logic [8:0] res_din;
   logic [0:0] res_tag;
   logic       res_full, snk_valid, snk_ready;
   logic [7:0] snk_data;
   logic       done, err, busy;
`ifdef FEEDER_CHECKSUM_EN
   logic [15:0] chk;
`endif

   int checks = 0;
   int errors = 0;
   logic [8:0] pel_q[$];

   always #5 clk = ~clk;

   hevc_filter_feeder dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_size(cmd_size), .cmd_tap8(cmd_tap8),
      .cmd_v_alpha(cmd_v_alpha), .cmd_h_alpha(cmd_h_alpha), .cmd_tag(cmd_tag),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .cfg_write(cfg_write), .cfg_v_din(cfg_v_din), .cfg_h_din(cfg_h_din),
      .cfg_size_din(cfg_size_din), .cfg_full(cfg_full),
      .pel_write(pel_write), .pel_din(pel_din), .pel_tag(pel_tag), .cfg_tag(cfg_tag),
      .pel_full(pel_full),
      .res_write(res_write), .res_din(res_din), .res_tag(res_tag), .res_full(res_full),
      .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
      .done(done), .err(err),
`ifdef FEEDER_CHECKSUM_EN
      .chk(chk),
`endif
      .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      cmd_valid = 1'b0; cmd_size = '0; cmd_tap8 = 1'b0; cmd_v_alpha = '0; cmd_h_alpha = '0;
      cmd_tag = '0; src_valid = 1'b0; src_data = '0; cfg_full = '0; pel_full = '0;
      res_write = 1'b0; res_din = '0; res_tag = '0; snk_ready = 1'b1;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
      check_eq({tag, "_busy"}, 32'(busy), 0);
      check_eq({tag, "_done"}, 32'(done), 0);
      check_eq({tag, "_err"}, 32'(err), 0);
      check_eq({tag, "_cfg_write"}, 32'(cfg_write), 0);
      check_eq({tag, "_cfg_dins"}, 32'({cfg_v_din, cfg_h_din, cfg_size_din}), 0);
      check_eq({tag, "_pel_write"}, 32'(pel_write), 0);
      check_eq({tag, "_pel_din"}, 32'(pel_din), 0);
      check_eq({tag, "_tags"}, 32'({pel_tag, cfg_tag}), 0);
      check_eq({tag, "_src_ready"}, 32'(src_ready), 0);
`ifdef FEEDER_CHECKSUM_EN
      check_eq({tag, "_chk"}, 32'(chk), 0);
`endif
   endtask

   // bad_mode: 0 none, 1 one result with the other flux tag, 2 one result with flag bit clear.
   task automatic run_job(input int size, input bit tap8, input int v_a, input int h_a, input int tag,
                          input bit toggle_full, input int cfg_hold, input int bad_mode,
                          input int abort_at);
      int ext, n_in, n_out, pushed, seen, outs, cfg_seen, done_cnt, cyc, tail;
      bit exp_pel, exp_err, bad_now, bad_sent, comp_checked, fin, aborted, ready_exp, xfer;
      logic [15:0] sum;
      logic [7:0]  d;
      ext = size + (tap8 ? 7 : 3);
      n_in = ext * ext;
      n_out = size * size;
      pushed = 0; seen = 0; outs = 0; cfg_seen = 0; done_cnt = 0; cyc = 0; tail = 0;
      exp_pel = 0; exp_err = 0; bad_sent = 0; comp_checked = 0; fin = 0; aborted = 0;
      sum = '0;
      pel_q.delete();

      @(negedge clk);
      cmd_size = 7'(size); cmd_tap8 = tap8; cmd_v_alpha = 3'(v_a); cmd_h_alpha = 3'(h_a);
      cmd_tag = 1'(tag); cmd_valid = 1'b1;
      cfg_full = (cfg_hold > 0) ? 2'(1 << tag) : 2'b00;
      check_eq("cmd_ready_idle", 32'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("busy_start", 32'(busy), 1);

      while (!fin && cyc < 20000) begin
         check_eq("err", 32'(err), 32'(exp_err));
         if (cfg_full[tag]) check_eq("cfg_held", 32'(cfg_write), 0);
         if (cfg_write) begin
            cfg_seen++;
            check_eq("cfg_v_din", 32'(cfg_v_din), 32'(8 + v_a));
            check_eq("cfg_h_din", 32'(cfg_h_din), 32'(8 + h_a));
            check_eq("cfg_size_din", 32'(cfg_size_din), 32'(128 + ext));
            check_eq("cfg_tag", 32'(cfg_tag), 32'(tag));
         end
         check_eq("pel_write", 32'(pel_write), 32'(exp_pel));
         if (pel_write) begin
            seen++;
            check_eq("pel_tag", 32'(pel_tag), 32'(tag));
            if (pel_q.size() != 0) check_eq("pel_din", 32'(pel_din), 32'(pel_q.pop_front()));
         end else begin
            check_eq("pel_din_idle", 32'(pel_din), 0);
         end

         if (abort_at > 0 && seen == abort_at) begin
            rst = 1'b0;
            drive_idle();
            #1;
            check_reset_state("abort");
            @(negedge clk);
            check_reset_state("abort_hold");
            rst = 1'b1;
            #1;
            check_eq("abort_cmd_ready", 32'(cmd_ready), 1);
            check_eq("abort_busy", 32'(busy), 0);
            aborted = 1;
            fin = 1;
         end else begin
            if (seen == n_in && outs == n_out && !comp_checked) begin
               comp_checked = 1;
               check_eq("done_on_complete", 32'(done), 1);
            end
            if (done) begin
               done_cnt++;
               check_eq("done_pels", 32'(seen), 32'(n_in));
               check_eq("done_outs", 32'(outs), 32'(n_out));
               check_eq("done_busy", 32'(busy), 0);
               check_eq("done_cmd_ready", 32'(cmd_ready), 1);
`ifdef FEEDER_CHECKSUM_EN
               check_eq("done_chk", 32'(chk), 32'(sum));
`endif
            end
            if (comp_checked) begin
               tail++;
               if (tail > 6) fin = 1;
            end

            pel_full = 2'b00;
            if (toggle_full) begin
               pel_full[tag ^ 1] = 1'b1;
               pel_full[tag] = ((cyc / 3) % 2) == 1;
            end
            cfg_full = (cyc < cfg_hold) ? 2'(1 << tag) : 2'b00;
            src_valid = (pushed < n_in) && ($urandom_range(0, 3) != 0);
            src_data = 8'($urandom);
            res_write = 1'b0; res_tag = 1'(tag); res_din = '0; bad_now = 0;
            snk_ready = ($urandom_range(0, 3) != 0);
            if (bad_mode != 0 && !bad_sent && seen >= 10) begin
               d = 8'($urandom);
               res_write = 1'b1; bad_now = 1; bad_sent = 1;
               if (bad_mode == 1) begin
                  res_tag = 1'(tag ^ 1);
                  res_din = {1'b1, d};
               end else begin
                  res_din = {1'b0, d};
               end
            end else if (seen >= n_in / 2 && outs < n_out && snk_ready && $urandom_range(0, 1) == 1) begin
               d = 8'($urandom);
               res_write = 1'b1;
               res_din = {1'b1, d};
               outs++;
               sum = sum + 16'(d);
            end
            #1;
            ready_exp = (cfg_seen > 0) && (pushed < n_in) && !pel_full[tag];
            check_eq("src_ready", 32'(src_ready), 32'(ready_exp));
            xfer = src_valid && ready_exp;
            if (xfer) begin
               pel_q.push_back({1'b1, src_data});
               pushed++;
            end
            exp_pel = xfer;
            exp_err = bad_now;
            check_eq("snk_valid", 32'(snk_valid), 32'(res_write));
            check_eq("snk_data", 32'(snk_data), 32'(res_din[7:0]));
            check_eq("res_full", 32'(res_full), 32'(!snk_ready));
         end
         @(negedge clk);
         cyc++;
      end

      if (!aborted) begin
         check_eq("job_finished", 32'(fin), 1);
         check_eq("done_count", 32'(done_cnt), 1);
         check_eq("pel_count", 32'(seen), 32'(n_in));
         check_eq("cfg_count", 32'(cfg_seen), 1);
         check_eq("pel_q_empty", 32'(pel_q.size()), 0);
      end
      drive_idle();
   endtask

   task automatic illegal_cmd();
      @(negedge clk);
      cmd_size = 7'd12; cmd_tap8 = 1'b1; cmd_tag = 1'b0; cmd_valid = 1'b1; src_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("illegal_err", 32'(err), 1);
      check_eq("illegal_busy", 32'(busy), 0);
      check_eq("illegal_cmd_ready_drop", 32'(cmd_ready), 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("illegal_cfg_write", 32'(cfg_write), 0);
         check_eq("illegal_pel_write", 32'(pel_write), 0);
         check_eq("illegal_busy_hold", 32'(busy), 0);
         check_eq("illegal_err_single", 32'(err), 0);
         check_eq("illegal_src_ready", 32'(src_ready), 0);
      end
      check_eq("illegal_cmd_ready", 32'(cmd_ready), 1);
      drive_idle();
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      drive_idle();
      #12;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("post_reset_cmd_ready", 32'(cmd_ready), 1);

      run_job(16, 1'b1, 2, 2, 0, 1'b0, 0, 0, 0);
      run_job(4, 1'b0, 5, 1, 1, 1'b0, 4, 0, 0);
      run_job(16, 1'b1, 1, 6, 0, 1'b1, 0, 0, 0);
      illegal_cmd();
      run_job(8, 1'b1, 3, 3, 0, 1'b0, 0, 1, 0);
      run_job(4, 1'b1, 0, 7, 1, 1'b0, 0, 2, 0);
      run_job(8, 1'b1, 2, 2, 1, 1'b0, 0, 0, 20);
      run_job(4, 1'b0, 4, 4, 0, 1'b0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
